// File: rtl/ysyx_23060136_write_arbiter_pkg.sv
// Shared types for the AXI4 write-path arbiter.
// FSM states and write-owner encodings.
package ysyx_23060136_write_arbiter_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  typedef enum logic {
    W_DC  = 1'b0,
    W_MEM = 1'b1
  } wown_t;

endpackage

// File: rtl/ysyx_23060136_rr_pick2.sv
// Two-way round-robin selector, one-hot result.
// Bit 0 is DC, bit 1 is MEM; a tie goes to whoever did not win last.
module ysyx_23060136_rr_pick2
  import ysyx_23060136_write_arbiter_pkg::*;
(
  input  logic       v0,
  input  logic       v1,
  input  wown_t      lg,
  output logic [1:0] pick
);

  always_comb begin
    pick = {v1, v0};
    if (v0 && v1)
      pick = (lg == W_MEM) ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/ysyx_23060136_write_arbiter.sv
// Shares the SoC AXI4 AW/W/B path between D-cache writeback and MEM stores.
// One transaction at a time, owner held from AW acceptance to B handshake.
module ysyx_23060136_write_arbiter
  import ysyx_23060136_write_arbiter_pkg::*;
#(
  parameter int BEAT_CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WARB_DC_awvalid,
  input  logic [31:0] WARB_DC_awaddr,
  input  logic [3:0]  WARB_DC_awid,
  input  logic [7:0]  WARB_DC_awlen,
  input  logic [2:0]  WARB_DC_awsize,
  input  logic [1:0]  WARB_DC_awburst,
  output logic        WARB_DC_awready,
  input  logic        WARB_DC_wvalid,
  input  logic [63:0] WARB_DC_wdata,
  input  logic [7:0]  WARB_DC_wstrb,
  input  logic        WARB_DC_wlast,
  output logic        WARB_DC_wready,
  output logic        WARB_DC_bvalid,
  output logic [1:0]  WARB_DC_bresp,
  output logic [3:0]  WARB_DC_bid,
  input  logic        WARB_DC_bready,
  input  logic        WARB_MEM_awvalid,
  input  logic [31:0] WARB_MEM_awaddr,
  input  logic [3:0]  WARB_MEM_awid,
  input  logic [7:0]  WARB_MEM_awlen,
  input  logic [2:0]  WARB_MEM_awsize,
  input  logic [1:0]  WARB_MEM_awburst,
  output logic        WARB_MEM_awready,
  input  logic        WARB_MEM_wvalid,
  input  logic [63:0] WARB_MEM_wdata,
  input  logic [7:0]  WARB_MEM_wstrb,
  input  logic        WARB_MEM_wlast,
  output logic        WARB_MEM_wready,
  output logic        WARB_MEM_bvalid,
  output logic [1:0]  WARB_MEM_bresp,
  output logic [3:0]  WARB_MEM_bid,
  input  logic        WARB_MEM_bready,
  output logic        io_master_awvalid,
  output logic [31:0] io_master_awaddr,
  output logic [3:0]  io_master_awid,
  output logic [7:0]  io_master_awlen,
  output logic [2:0]  io_master_awsize,
  output logic [1:0]  io_master_awburst,
  input  logic        io_master_awready,
  output logic        io_master_wvalid,
  output logic [63:0] io_master_wdata,
  output logic [7:0]  io_master_wstrb,
  output logic        io_master_wlast,
  input  logic        io_master_wready,
  input  logic        io_master_bvalid,
  input  logic [1:0]  io_master_bresp,
  input  logic [3:0]  io_master_bid,
  output logic        io_master_bready,
  output logic        wr_err
);

  wstate_t               state, state_n;
  wown_t                 owner, owner_n;
  wown_t                 lg, lg_n;
  logic [BEAT_CNT_W-1:0] beats, beats_n;
  logic                  err_n;
  logic [1:0]            pick;
  logic                  own_mem;
  logic                  run;

  ysyx_23060136_rr_pick2 u_pick (
    .v0   (WARB_DC_awvalid),
    .v1   (WARB_MEM_awvalid),
    .lg   (lg),
    .pick (pick)
  );

  assign own_mem = (owner == W_MEM);
  assign run     = ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= W_IDLE;
      owner  <= W_DC;
      lg     <= W_MEM;
      beats  <= '0;
      wr_err <= 1'b0;
    end else begin
      state  <= state_n;
      owner  <= owner_n;
      lg     <= lg_n;
      beats  <= beats_n;
      wr_err <= err_n;
    end
  end

  // AW fields follow the combinational pick; W fields follow the owner.
  always_comb begin
    io_master_awaddr  = pick[1] ? WARB_MEM_awaddr  : WARB_DC_awaddr;
    io_master_awid    = pick[1] ? WARB_MEM_awid    : WARB_DC_awid;
    io_master_awlen   = pick[1] ? WARB_MEM_awlen   : WARB_DC_awlen;
    io_master_awsize  = pick[1] ? WARB_MEM_awsize  : WARB_DC_awsize;
    io_master_awburst = pick[1] ? WARB_MEM_awburst : WARB_DC_awburst;
    io_master_wdata   = own_mem ? WARB_MEM_wdata : WARB_DC_wdata;
    io_master_wstrb   = own_mem ? WARB_MEM_wstrb : WARB_DC_wstrb;
    io_master_wlast   = own_mem ? WARB_MEM_wlast : WARB_DC_wlast;
    WARB_DC_bresp     = own_mem ? 2'b00 : io_master_bresp;
    WARB_DC_bid       = own_mem ? 4'h0  : io_master_bid;
    WARB_MEM_bresp    = own_mem ? io_master_bresp : 2'b00;
    WARB_MEM_bid      = own_mem ? io_master_bid   : 4'h0;
  end

  always_comb begin
    state_n           = state;
    owner_n           = owner;
    lg_n              = lg;
    beats_n           = beats;
    err_n             = wr_err;
    io_master_awvalid = 1'b0;
    io_master_wvalid  = 1'b0;
    io_master_bready  = 1'b0;
    WARB_DC_awready   = 1'b0;
    WARB_MEM_awready  = 1'b0;
    WARB_DC_wready    = 1'b0;
    WARB_MEM_wready   = 1'b0;
    WARB_DC_bvalid    = 1'b0;
    WARB_MEM_bvalid   = 1'b0;
    unique case (state)
      W_IDLE: begin
        io_master_awvalid = (WARB_DC_awvalid | WARB_MEM_awvalid) & run;
        WARB_DC_awready   = pick[0] & io_master_awready & run;
        WARB_MEM_awready  = pick[1] & io_master_awready & run;
        if (io_master_awvalid && io_master_awready) begin
          owner_n = pick[1] ? W_MEM : W_DC;
          lg_n    = owner_n;
          beats_n = BEAT_CNT_W'(io_master_awlen);
          state_n = W_DATA;
        end
      end
      W_DATA: begin
        io_master_wvalid = (own_mem ? WARB_MEM_wvalid : WARB_DC_wvalid) & run;
        WARB_DC_wready   = ~own_mem & io_master_wready & run;
        WARB_MEM_wready  = own_mem & io_master_wready & run;
        if (io_master_wvalid && io_master_wready) begin
          if (io_master_wlast) begin
            state_n = W_RESP;
            if (beats != '0) err_n = 1'b1;
          end else if (beats == '0) begin
            err_n = 1'b1;
          end else begin
            beats_n = beats - 1'b1;
          end
        end
      end
      W_RESP: begin
        io_master_bready = (own_mem ? WARB_MEM_bready : WARB_DC_bready) & run;
        WARB_DC_bvalid   = ~own_mem & io_master_bvalid & run;
        WARB_MEM_bvalid  = own_mem & io_master_bvalid & run;
        if (io_master_bvalid && io_master_bready)
          state_n = W_IDLE;
      end
      default: state_n = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_23060136_write_arbiter.sv
// Directed bench for the write arbiter with a W-data scoreboard.
// Slave side of the AXI write path is driven from the stimulus sequence.
module tb_ysyx_23060136_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        dc_awvalid, dc_awready, dc_wvalid, dc_wlast, dc_wready;
  logic        dc_bvalid, dc_bready;
  logic [31:0] dc_awaddr;
  logic [3:0]  dc_awid, dc_bid;
  logic [7:0]  dc_awlen, dc_wstrb;
  logic [2:0]  dc_awsize;
  logic [1:0]  dc_awburst, dc_bresp;
  logic [63:0] dc_wdata;
  logic        mem_awvalid, mem_awready, mem_wvalid, mem_wlast, mem_wready;
  logic        mem_bvalid, mem_bready;
  logic [31:0] mem_awaddr;
  logic [3:0]  mem_awid, mem_bid;
  logic [7:0]  mem_awlen, mem_wstrb;
  logic [2:0]  mem_awsize;
  logic [1:0]  mem_awburst, mem_bresp;
  logic [63:0] mem_wdata;
  logic        io_master_awvalid, io_master_awready;
  logic [31:0] io_master_awaddr;
  logic [3:0]  io_master_awid, io_master_bid;
  logic [7:0]  io_master_awlen, io_master_wstrb;
  logic [2:0]  io_master_awsize;
  logic [1:0]  io_master_awburst, io_master_bresp;
  logic        io_master_wvalid, io_master_wready, io_master_wlast;
  logic [63:0] io_master_wdata;
  logic        io_master_bvalid, io_master_bready;
  logic        wr_err;

  int          n_chk = 0;
  int          n_fail = 0;
  int          n_wbeats = 0;
  int          wb0;
  logic [63:0] sb[$];
  logic [63:0] exp_d;

  always #5 clk = ~clk;

  ysyx_23060136_write_arbiter #(.BEAT_CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .WARB_DC_awvalid(dc_awvalid), .WARB_DC_awaddr(dc_awaddr),
    .WARB_DC_awid(dc_awid), .WARB_DC_awlen(dc_awlen),
    .WARB_DC_awsize(dc_awsize), .WARB_DC_awburst(dc_awburst),
    .WARB_DC_awready(dc_awready), .WARB_DC_wvalid(dc_wvalid),
    .WARB_DC_wdata(dc_wdata), .WARB_DC_wstrb(dc_wstrb),
    .WARB_DC_wlast(dc_wlast), .WARB_DC_wready(dc_wready),
    .WARB_DC_bvalid(dc_bvalid), .WARB_DC_bresp(dc_bresp),
    .WARB_DC_bid(dc_bid), .WARB_DC_bready(dc_bready),
    .WARB_MEM_awvalid(mem_awvalid), .WARB_MEM_awaddr(mem_awaddr),
    .WARB_MEM_awid(mem_awid), .WARB_MEM_awlen(mem_awlen),
    .WARB_MEM_awsize(mem_awsize), .WARB_MEM_awburst(mem_awburst),
    .WARB_MEM_awready(mem_awready), .WARB_MEM_wvalid(mem_wvalid),
    .WARB_MEM_wdata(mem_wdata), .WARB_MEM_wstrb(mem_wstrb),
    .WARB_MEM_wlast(mem_wlast), .WARB_MEM_wready(mem_wready),
    .WARB_MEM_bvalid(mem_bvalid), .WARB_MEM_bresp(mem_bresp),
    .WARB_MEM_bid(mem_bid), .WARB_MEM_bready(mem_bready),
    .io_master_awvalid(io_master_awvalid), .io_master_awaddr(io_master_awaddr),
    .io_master_awid(io_master_awid), .io_master_awlen(io_master_awlen),
    .io_master_awsize(io_master_awsize), .io_master_awburst(io_master_awburst),
    .io_master_awready(io_master_awready), .io_master_wvalid(io_master_wvalid),
    .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
    .io_master_wlast(io_master_wlast), .io_master_wready(io_master_wready),
    .io_master_bvalid(io_master_bvalid), .io_master_bresp(io_master_bresp),
    .io_master_bid(io_master_bid), .io_master_bready(io_master_bready),
    .wr_err(wr_err)
  );

  task automatic chk(input string tag, input bit ok);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && io_master_wvalid && io_master_wready) begin
      n_wbeats++;
      chk("sb_underflow", sb.size() !== 0);
      if (sb.size() != 0) begin
        exp_d = sb.pop_front();
        chk("wdata", io_master_wdata === exp_d);
      end
    end
  end

  task automatic drv_aw(input bit m, input logic v, input logic [31:0] a, input logic [7:0] l);
    if (m) begin mem_awvalid = v; mem_awaddr = a; mem_awlen = l; end
    else begin dc_awvalid = v; dc_awaddr = a; dc_awlen = l; end
  endtask

  task automatic drv_w(input bit m, input logic v, input logic [63:0] d, input logic last);
    if (m) begin mem_wvalid = v; mem_wdata = d; mem_wlast = last; end
    else begin dc_wvalid = v; dc_wdata = d; dc_wlast = last; end
  endtask

  task automatic drv_br(input bit m, input logic r);
    if (m) mem_bready = r;
    else dc_bready = r;
  endtask

  task automatic do_write(input bit m, input logic [7:0] len, input int nb,
                          input int aw_st, input int w_st,
                          input logic [1:0] resp, input logic [3:0] id,
                          input logic [31:0] addr);
    logic [63:0] d;
    drv_aw(m, 1'b1, addr, len);
    d = {addr, 32'd0};
    drv_w(m, 1'b1, d, nb == 1);
    sb.push_back(d);
    io_master_awready = 1'b0;
    repeat (aw_st) begin
      @(negedge clk);
      chk("aw_stall_valid", io_master_awvalid === 1'b1);
      chk("aw_stall_rdy", (m ? mem_awready : dc_awready) === 1'b0);
      chk("aw_stall_other", (m ? dc_awready : mem_awready) === 1'b0);
      @(posedge clk); #1;
    end
    io_master_awready = 1'b1;
    @(negedge clk);
    chk("aw_valid", io_master_awvalid === 1'b1);
    chk("aw_addr", io_master_awaddr === addr);
    chk("aw_len", io_master_awlen === len);
    chk("aw_rdy", (m ? mem_awready : dc_awready) === 1'b1);
    chk("aw_other_rdy", (m ? dc_awready : mem_awready) === 1'b0);
    chk("w_in_aw_cycle", io_master_wvalid === 1'b0);
    @(posedge clk); #1;
    drv_aw(m, 1'b0, addr, len);
    io_master_awready = 1'b0;
    io_master_wready  = 1'b0;
    repeat (w_st) begin
      @(negedge clk);
      chk("w_stall_valid", io_master_wvalid === 1'b1);
      chk("w_stall_rdy", (m ? mem_wready : dc_wready) === 1'b0);
      chk("w_stall_other", (m ? dc_wready : mem_wready) === 1'b0);
      @(posedge clk); #1;
    end
    io_master_wready = 1'b1;
    for (int i = 0; i < nb; i++) begin
      if (i > 0) begin
        d = {addr, 32'(i)};
        drv_w(m, 1'b1, d, i == nb - 1);
        sb.push_back(d);
      end
      @(negedge clk);
      chk("w_rdy", (m ? mem_wready : dc_wready) === 1'b1);
      chk("w_other_rdy", (m ? dc_wready : mem_wready) === 1'b0);
      chk("aw_in_data", io_master_awvalid === 1'b0);
      @(posedge clk); #1;
    end
    drv_w(m, 1'b0, 64'd0, 1'b0);
    io_master_wready = 1'b0;
    io_master_bvalid = 1'b1;
    io_master_bresp  = resp;
    io_master_bid    = id;
    drv_br(m, 1'b1);
    @(negedge clk);
    chk("b_valid", (m ? mem_bvalid : dc_bvalid) === 1'b1);
    chk("b_resp", (m ? mem_bresp : dc_bresp) === resp);
    chk("b_id", (m ? mem_bid : dc_bid) === id);
    chk("b_ready", io_master_bready === 1'b1);
    chk("b_other_valid", (m ? dc_bvalid : mem_bvalid) === 1'b0);
    chk("b_other_resp", (m ? dc_bresp : mem_bresp) === 2'b00);
    chk("b_other_id", (m ? dc_bid : mem_bid) === 4'h0);
    @(posedge clk); #1;
    io_master_bvalid = 1'b0;
    io_master_bresp  = 2'b00;
    io_master_bid    = 4'h0;
    drv_br(m, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    dc_awvalid = 1'b1; dc_awaddr = 32'h0; dc_awid = 4'h1; dc_awlen = 8'd0;
    dc_awsize = 3'd3; dc_awburst = 2'b01; dc_wvalid = 1'b1; dc_wdata = '0;
    dc_wstrb = 8'hff; dc_wlast = 1'b0; dc_bready = 1'b1;
    mem_awvalid = 1'b0; mem_awaddr = 32'h0; mem_awid = 4'h2; mem_awlen = 8'd0;
    mem_awsize = 3'd2; mem_awburst = 2'b01; mem_wvalid = 1'b0; mem_wdata = '0;
    mem_wstrb = 8'h0f; mem_wlast = 1'b0; mem_bready = 1'b0;
    io_master_awready = 1'b1; io_master_wready = 1'b1;
    io_master_bvalid = 1'b1; io_master_bresp = 2'b00; io_master_bid = 4'h0;

    @(negedge clk);
    chk("rst_awvalid", io_master_awvalid === 1'b0);
    chk("rst_dc_awready", dc_awready === 1'b0);
    chk("rst_wvalid", io_master_wvalid === 1'b0);
    chk("rst_bready", io_master_bready === 1'b0);
    chk("rst_dc_bvalid", dc_bvalid === 1'b0);
    chk("rst_wr_err", wr_err === 1'b0);
    dc_awvalid = 1'b0; dc_wvalid = 1'b0; dc_bready = 1'b0;
    io_master_awready = 1'b0; io_master_wready = 1'b0; io_master_bvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    drv_aw(1'b1, 1'b1, 32'h8000_1000, 8'd0);
    wb0 = n_wbeats;
    do_write(1'b0, 8'd3, 4, 0, 0, 2'b00, 4'h1, 32'h8000_0040);
    chk("dc_burst_beats", (n_wbeats - wb0) === 4);
    chk("dc_burst_err", wr_err === 1'b0);
    drv_aw(1'b0, 1'b1, 32'h8000_2000, 8'd0);
    do_write(1'b1, 8'd0, 1, 0, 0, 2'b00, 4'h2, 32'h8000_1000);
    drv_aw(1'b1, 1'b1, 32'h8000_3000, 8'd0);
    do_write(1'b0, 8'd0, 1, 0, 0, 2'b00, 4'h1, 32'h8000_2000);
    drv_aw(1'b1, 1'b0, 32'h0, 8'd0);

    wb0 = n_wbeats;
    do_write(1'b0, 8'd3, 4, 0, 0, 2'b00, 4'h1, 32'h8000_0080);
    chk("dc_alone_beats", (n_wbeats - wb0) === 4);
    chk("dc_alone_err", wr_err === 1'b0);

    do_write(1'b1, 8'd0, 1, 5, 3, 2'b10, 4'h5, 32'h1000_0004);
    chk("slverr_no_wr_err", wr_err === 1'b0);

    wb0 = n_wbeats;
    do_write(1'b0, 8'd3, 2, 0, 0, 2'b00, 4'h1, 32'h8000_00c0);
    chk("early_last_beats", (n_wbeats - wb0) === 2);
    chk("early_last_err", wr_err === 1'b1);
    do_write(1'b1, 8'd0, 1, 0, 0, 2'b00, 4'h3, 32'h1000_0008);
    chk("err_sticky", wr_err === 1'b1);

    drv_aw(1'b0, 1'b1, 32'h8000_0100, 8'd3);
    io_master_awready = 1'b1;
    @(posedge clk); #1;
    drv_aw(1'b0, 1'b0, 32'h8000_0100, 8'd3);
    io_master_awready = 1'b0;
    drv_w(1'b0, 1'b1, {32'h8000_0100, 32'd0}, 1'b0);
    sb.push_back({32'h8000_0100, 32'd0});
    io_master_wready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    drv_w(1'b0, 1'b1, {32'h8000_0100, 32'd1}, 1'b0);
    dc_awvalid = 1'b1;
    #1;
    chk("mid_rst_wvalid", io_master_wvalid === 1'b0);
    chk("mid_rst_wready", dc_wready === 1'b0);
    chk("mid_rst_awvalid", io_master_awvalid === 1'b0);
    chk("mid_rst_err", wr_err === 1'b0);
    @(negedge clk);
    drv_w(1'b0, 1'b0, 64'd0, 1'b0);
    io_master_wready = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_wvalid", io_master_wvalid === 1'b0);
    drv_aw(1'b1, 1'b1, 32'h1000_0010, 8'd0);
    do_write(1'b0, 8'd1, 2, 0, 0, 2'b00, 4'h1, 32'h8000_0140);
    do_write(1'b1, 8'd0, 1, 0, 0, 2'b01, 4'h7, 32'h1000_0010);
    chk("post_rst_err", wr_err === 1'b0);
    chk("sb_drained", sb.size() === 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
